data_mem_lsu: RTL and testbench

//  Load/store initiator driving the word-addressed single-port data memory (combinational read, negedge write).

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_lane_unit.sv | 40 ++++
 rtl/data_mem_lsu.sv | 132 +++++++++++++
 tb/tb_data_mem_lsu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM states, lane count.
package lsu_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_ERR,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: little-endian load extract with sign/zero extension,
// and the read-modify-write merge of sub-word store data into the fetched word.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  lsu_size_e          size_i,
    input  logic [1:0]         lane_i,
    input  logic               uns_i,
    input  logic [LANES*8-1:0] rdata_i,
    input  logic [15:0]        wdata_i,
    output logic [LANES*8-1:0] load_o,
    output logic [LANES*8-1:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        load_o = rdata_i;
        unique case (size_i)
            SZ_BYTE: load_o = {{24{byte_sel[7] & ~uns_i}}, byte_sel};
            SZ_HALF: load_o = {{16{half_sel[15] & ~uns_i}}, half_sel};
            default: load_o = rdata_i;
        endcase

        merged_o = rdata_i;
        unique case (size_i)
            SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            SZ_HALF: begin
                if (lane_i[1]) merged_o[31:16] = wdata_i;
                else           merged_o[15:0]  = wdata_i;
            end
            default: merged_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store initiator for the word-addressed data memory (combinational read, negedge write).
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning them.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_WORDS = 101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-3:0] LAST_WORD = (ADDR_W-2)'(MEM_WORDS);

    lsu_state_e        state_q, state_d;
    logic              we_q, uns_q;
    lsu_size_e         size_q;
    logic [1:0]        lane_q;
    logic [15:0]       wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, resp_rdata_q;
    logic              resp_valid_q, resp_err_q;

    lsu_size_e   req_sz;
    logic        accept, misalign, bad_req;
    logic [1:0]  eff_lane;
    logic [DATA_W-1:0] load_data, merged_word;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign req_sz    = lsu_size_e'(req_size);

    always_comb begin
        eff_lane = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((req_sz == SZ_HALF) && req_addr[0]) ||
                   ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
        if (req_sz == SZ_HALF) eff_lane = {req_addr[1], 1'b0};
        if (req_sz == SZ_WORD) eff_lane = 2'b00;
`endif
        bad_req = (req_sz == SZ_RSVD) || (req_addr[ADDR_W-1:2] >= LAST_WORD) || misalign;
    end

    // Word stores skip the read; every other good request fetches the word first.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_req)                            state_d = ST_ERR;
                    else if (req_we && (req_sz == SZ_WORD)) state_d = ST_WR;
                    else                                    state_d = ST_RD;
                end
            end
            ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_ERR:  state_d = ST_IDLE;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    lsu_lane_unit u_lane (
        .size_i  (size_q),
        .lane_i  (lane_q),
        .uns_i   (uns_q),
        .rdata_i (mem_rdata),
        .wdata_i (wdata_q),
        .load_o  (load_data),
        .merged_o(merged_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= SZ_BYTE;
            lane_q       <= '0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= (state_d == ST_RESP) || (state_d == ST_ERR);
            resp_err_q   <= (state_d == ST_ERR);
            resp_rdata_q <= (state_q == ST_RD && !we_q) ? load_data : '0;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_sz;
                lane_q  <= eff_lane;
                wdata_q <= req_wdata[15:0];
                if (!bad_req) begin
                    mem_addr_q  <= {2'b00, req_addr[ADDR_W-1:2]};
                    mem_wdata_q <= req_wdata;
                end
            end
            if (state_q == ST_RD && we_q) mem_wdata_q <= merged_word;
        end
    end

    assign mem_read   = (state_q == ST_RD);
    assign mem_write  = (state_q == ST_WR);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed vector table, reset-abort sequence,
// and randomized traffic against an arithmetic reference of the memory contents.
module tb_data_mem_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int unsigned NW = 101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] tb_mem [0:NW-1];
    logic [31:0] ref_mem [0:NW-1];
    bit          mem_load = 1'b1;
    int          checks = 0, failures = 0, overlap = 0;

    always #5 clk = ~clk;

    data_mem_lsu #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(NW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 3) return 32'h8899AABB;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Memory behind the DUT: combinational read, negedge write.
    assign mem_rdata = (mem_addr < 32'(NW)) ? tb_mem[mem_addr[6:0]] : '0;
    always @(negedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < NW; i++) tb_mem[i] <= init_word(i);
        end else if (mem_write && mem_addr < 32'(NW)) begin
            tb_mem[mem_addr[6:0]] <= mem_wdata;
        end
        if (mem_read && mem_write) overlap++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed access rules evaluated with plain arithmetic.
    task automatic ref_op(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output bit err, output int lat,
                          output int nr, output int nw, output logic [31:0] widx_o,
                          output logic [31:0] wword);
        longint unsigned widx = longint'(addr) / 4;
        int off = int'(addr % 4);
        int nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        longint unsigned mask, word, v;
        rd = '0; nr = 0; nw = 0; wword = '0; widx_o = 32'(widx);
        err = (sz == 2'd3) || (widx >= NW) || (TRAP && (off % nbytes != 0));
        if (err) begin
            lat = 1;
            return;
        end
        off  = off - (off % nbytes);
        mask = (64'd1 << (8 * nbytes)) - 1;
        word = longint'(ref_mem[widx]);
        if (!we) begin
            v = (word >> (8 * off)) & mask;
            if (!uns && nbytes < 4 && v >= (mask + 1) / 2) v = v + 64'h1_0000_0000 - (mask + 1);
            rd = v[31:0];
            nr = 1;
            lat = 2;
        end else begin
            v = (word & ~(mask << (8 * off))) | ((longint'(wd) & mask) << (8 * off));
            ref_mem[widx] = v[31:0];
            wword = v[31:0];
            nr = (nbytes < 4) ? 1 : 0;
            nw = 1;
            lat = (nbytes < 4) ? 3 : 2;
        end
    endtask

    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output bit err, output int lat,
                          output int nr, output int nw, output logic [31:0] sa,
                          output logic [31:0] sw);
        int guard = 0;
        rd = '0; err = 1'b0; lat = 0; nr = 0; nw = 0; sa = '0; sw = '0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1) != 0; req_size = 2'($urandom);
        req_unsigned = $urandom_range(0, 1) != 0; req_addr = $urandom; req_wdata = $urandom;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            if (mem_read)  begin nr++; sa = mem_addr; end
            if (mem_write) begin nw++; sa = mem_addr; sw = mem_wdata; end
            if (resp_valid) begin lat = n; rd = resp_rdata; err = resp_err; end
        end
    endtask

    task automatic run_op(input string tag, input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd, input bit use_tab,
                          input logic [31:0] t_rd, input bit t_err, input int t_lat);
        logic [31:0] e_rd, e_wi, e_ww, a_rd, a_sa, a_sw;
        bit e_err, a_err;
        int e_lat, e_nr, e_nw, a_lat, a_nr, a_nw;
        ref_op(we, sz, uns, addr, wd, e_rd, e_err, e_lat, e_nr, e_nw, e_wi, e_ww);
        if (use_tab) begin
            e_rd = t_rd; e_err = t_err; e_lat = t_lat;
        end
        do_req(we, sz, uns, addr, wd, a_rd, a_err, a_lat, a_nr, a_nw, a_sa, a_sw);
        chk({tag, "_rdata"}, a_rd, e_rd);
        chk({tag, "_err"}, 32'(a_err), 32'(e_err));
        chk({tag, "_latency"}, 32'(a_lat), 32'(e_lat));
        chk({tag, "_reads"}, 32'(a_nr), 32'(e_nr));
        chk({tag, "_writes"}, 32'(a_nw), 32'(e_nw));
        if (e_nr + e_nw > 0) chk({tag, "_memaddr"}, a_sa, e_wi);
        if (e_nw > 0) chk({tag, "_memwdata"}, a_sw, e_ww);
    endtask

    typedef struct {
        bit          we;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [31:0] w1, w100;
        int guard;
        bit          saw_resp;
        w1   = init_word(1);
        w100 = init_word(100);
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h0D,  32'h0,        32'hFFFFFFAA, 1'b0, 2};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0D,  32'h0,        32'h000000AA, 1'b0, 2};
        vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h0E,  32'h0,        32'hFFFF8899, 1'b0, 2};
        vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h0E,  32'h55,       32'h0,        1'b0, 3};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h0C,  32'h0,        32'h8855AABB, 1'b0, 2};
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h12345678, 32'h0,        1'b0, 2};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h12345678, 1'b0, 2};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h196, 32'h0,        32'h0,        1'b1, 1};
        vecs[8]  = TRAP ? '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1}
                        : '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0, w1,    1'b0, 2};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h00,  32'h0,        32'h0,        1'b1, 1};
        vecs[10] = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        32'h00001234, 1'b0, 2};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h192, 32'hCAFEBEEF, 32'h0,        1'b0, 3};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h190, 32'h0,        {16'hBEEF, w100[15:0]}, 1'b0, 2};
        vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h1A0, 32'h0,        32'h0,        1'b1, 1};

        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
        repeat (3) @(negedge clk);
        mem_load = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        #1 rst = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("v%0d", i), vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr,
                   vecs[i].wd, 1'b1, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat);

        // Reset during the RD cycle of a load: the response must be dropped.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h08;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_rd", 32'(mem_read), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'd1);
        saw_resp = resp_valid;
        guard = 0;
        repeat (3) begin
            @(negedge clk);
            saw_resp |= resp_valid;
            guard++;
        end
        chk("abort_no_resp", 32'(saw_resp), 32'd0);
        run_op("post_abort_sw", 1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A5_1234, 1'b0, '0, 1'b0, 0);
        run_op("post_abort_lw", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, '0, 1'b0, 0);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NW * 4 + 7));
            run_op($sformatf("rnd%0d", k), $urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 1) != 0, a, $urandom, 1'b0, '0, 1'b0, 0);
        end

        @(negedge clk);
        for (int i = 0; i < NW; i++) chk($sformatf("mem_word%0d", i), tb_mem[i], ref_mem[i]);
        chk("rd_wr_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
